// File: rtl/mmio_pkg.sv
// Shared constants and address-region decode for the MMIO store buffer.
package mmio_pkg;
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_STATS  = 4'h8;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_UNMAPPED} region_t;

  // Window is 16 bytes starting at base; everything below is RAM.
  function automatic region_t decode_region(input logic [31:0] adr, input logic [31:0] base);
    if (adr < base)                return REG_RAM;
    else if ((adr - base) < 32'd16) return REG_IO;
    else                           return REG_UNMAPPED;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Registered-output synchronous FIFO; a full FIFO still accepts a push when it pops in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mmio_store_buffer.sv
// Data-port decode, read mux and MMIO store FIFO with sticky overflow.
// Optional drained-word counter at +8 when MMIO_STATS_EN is defined.
module mmio_store_buffer
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ram_we,
  input  logic [31:0] ram_rd,
  output logic        periph_valid,
  output logic [31:0] periph_data,
  input  logic        periph_ready
);
  localparam int AW = $clog2(DEPTH);

  region_t         region;
  logic [3:0]      off;
  logic            io_wr, push_req, stat_wr, pop, push_ok;
  logic            full, empty;
  logic [AW:0]     count;
  logic            ovf_q, ovf_d;
  logic [31:0]     status, stats_rd;

  assign region   = decode_region(DataAdr, IO_BASE);
  // Window is 16-byte aligned, so the low nibble is the register offset.
  assign off      = DataAdr[3:0];
  assign io_wr    = MemWrite && (region == REG_IO);
  assign push_req = io_wr && (off == OFF_DATA);
  assign stat_wr  = io_wr && (off == OFF_STATUS);
  assign ram_we   = MemWrite && (region == REG_RAM);

  assign periph_valid = !empty;
  assign pop          = periph_valid && periph_ready;

  sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push_req),
    .pop     (pop),
    .din     (WriteData),
    .dout    (periph_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .push_ok (push_ok)
  );

  // Rejected push beats a STATUS clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr)              ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

`ifdef MMIO_STATS_EN
  logic [31:0] stats_q, stats_d;
  logic        stats_wr;

  assign stats_wr = io_wr && (off == OFF_STATS);

  // Clear then count, so clear+pop in one cycle leaves 1.
  always_comb begin
    stats_d = stats_q;
    if (stats_wr) stats_d = '0;
    if (pop)      stats_d = stats_d + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stats_q <= '0;
    else        stats_q <= stats_d;
  end

  assign stats_rd = stats_q;
`else
  assign stats_rd = '0;
`endif

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_LSB +: 8]     = 8'(count);
  end

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM: ReadData = ram_rd;
      REG_IO: begin
        if (off == OFF_STATUS)     ReadData = status;
        else if (off == OFF_STATS) ReadData = stats_rd;
      end
      default: ReadData = '0;
    endcase
  end
endmodule

// File: tb/tb_mmio_store_buffer.sv
// Directed bench for mmio_store_buffer: decode vector table plus FIFO/overflow/reset/stats sequences.
module tb_mmio_store_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        ram_we;
  logic [31:0] ram_rd = '0;
  logic        periph_valid;
  logic [31:0] periph_data;
  logic        periph_ready = 1'b0;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [31:0] IOB = 32'h0000_1000;

  mmio_store_buffer #(.DEPTH(8), .IO_BASE(IOB)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .ram_we       (ram_we),
    .ram_rd       (ram_rd),
    .periph_valid (periph_valid),
    .periph_data  (periph_data),
    .periph_ready (periph_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rr;
    logic [31:0] exp_rd;
    logic        exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Drive a store for exactly one rising edge; returns at a falling edge with MemWrite low.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    MemWrite = 1'b0; DataAdr = a;
    #1 v = ReadData;
  endtask

  initial begin
    vec_t        vecs[11];
    logic [31:0] v;
    logic [31:0] exp_stats;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0FFC, 32'h1,         32'h0000_A5A5, 32'h0000_A5A5, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_1234, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_1004, 32'h0,         32'h0000_1234, 32'h0000_0001, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_1008, 32'h0,         32'h0000_1234, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0000_100C, 32'h0,         32'h0000_1234, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_100C, 32'h5,         32'h0000_1234, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_1010, 32'h7,         32'h0000_0055, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0055, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h0000_1004, 32'h0,         32'h0000_0099, 32'h0000_0001, 1'b0};

    #1 reset = 1'b0;
    #3;
    chk("rst_valid", {31'b0, periph_valid}, 32'h0);
    chk("rst_data", periph_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Decode / read-mux table, FIFO empty throughout
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      MemWrite = vecs[i].mw; DataAdr = vecs[i].adr; WriteData = vecs[i].wd; ram_rd = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      chk($sformatf("vec%0d_we", i), {31'b0, ram_we}, {31'b0, vecs[i].exp_we});
    end
    @(negedge clk);
    MemWrite = 1'b0;
    rd(IOB + 4, v); chk("ram_store_fifo_untouched", v, 32'h0000_0001);

    // Three pushes, then drain on consecutive cycles
    periph_ready = 1'b0;
    store(IOB, 32'h11); store(IOB, 32'h22); store(IOB, 32'h33);
    rd(IOB + 4, v); chk("status_3", v, 32'h0000_0300);
    chk("head_valid", {31'b0, periph_valid}, 32'h1);
    chk("head_11", periph_data, 32'h11);
    periph_ready = 1'b1;
    @(negedge clk); chk("drain_22", periph_data, 32'h22);
    @(negedge clk); chk("drain_33", periph_data, 32'h33);
    @(negedge clk); chk("drain_empty", {31'b0, periph_valid}, 32'h0);
    periph_ready = 1'b0;
    rd(IOB + 4, v); chk("status_empty", v, 32'h0000_0001);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) store(IOB, 32'h100 + i);
    rd(IOB + 4, v); chk("status_ovf", v, 32'h0000_0806);
    chk("ovf_head", periph_data, 32'h100);
    store(IOB + 4, 32'hFFFF_FFFF);
    rd(IOB + 4, v); chk("status_ovf_clr", v, 32'h0000_0802);

    // Full FIFO with a simultaneous pop accepts the push
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = IOB; WriteData = 32'hA0; periph_ready = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; periph_ready = 1'b0;
    rd(IOB + 4, v); chk("full_push_pop", v, 32'h0000_0802);
    chk("full_push_pop_head", periph_data, 32'h101);

    // Drain four, then reset mid-drain with ready still high
    periph_ready = 1'b1;
    repeat (4) @(negedge clk);
    rd(IOB + 4, v); chk("status_4", v, 32'h0000_0400);
    chk("head_105", periph_data, 32'h105);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, periph_valid}, 32'h0);
    chk("midrst_data", periph_data, 32'h0);
    rd(IOB + 4, v); chk("midrst_status", v, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b1;
    periph_ready = 1'b0;
    @(negedge clk);
    rd(IOB + 4, v); chk("postrst_status", v, 32'h0000_0001);

    // Drained-word counter
    for (int i = 0; i < 5; i++) store(IOB, 32'h200 + i);
    periph_ready = 1'b1;
    repeat (6) @(negedge clk);
    periph_ready = 1'b0;
`ifdef MMIO_STATS_EN
    exp_stats = 32'd5;
`else
    exp_stats = 32'd0;
`endif
    rd(IOB + 8, v); chk("stats_5", v, exp_stats);
    store(IOB, 32'h300);
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = IOB + 8; WriteData = 32'h0; periph_ready = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; periph_ready = 1'b0;
`ifdef MMIO_STATS_EN
    exp_stats = 32'd1;
`else
    exp_stats = 32'd0;
`endif
    rd(IOB + 8, v); chk("stats_clr_pop", v, exp_stats);
    rd(IOB + 4, v); chk("stats_status", v, 32'h0000_0001);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mmio_store_buffer.md
Name: mmio_store_buffer

Overview:
- Sits on the CPU data port, between the ARM core's MemWrite/DataAdr/WriteData/ReadData and the data RAM.
- Decodes addresses, gates RAM writes, and returns the read-data mux to the core.
- Captures stores to a memory-mapped I/O window into a FIFO, which drains to a slow peripheral over a valid/ready handshake.
- The single-cycle core cannot stall, so overflowing stores are dropped and flagged.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- IO_BASE, 32'h0000_1000, byte address of the 16-byte I/O window; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  32  byte address from the core.
- WriteData  in  32  store data from the core.
- ReadData  out  32  load data returned to the core.
- ram_we  out  1  write enable to the data RAM.
- ram_rd  in  32  read data from the data RAM.
- periph_valid  out  1  FIFO head is valid.
- periph_data  out  32  FIFO head word.
- periph_ready  in  1  peripheral accepts the head.

Behaviour:
- Address regions:
  - RAM: DataAdr < IO_BASE.
  - IO: IO_BASE <= DataAdr < IO_BASE+16.
  - Above the IO window: unmapped.
- IO offsets within the window:
  - +0 DATA: write pushes to the FIFO; read returns 0.
  - +4 STATUS: read returns status; write clears overflow, WriteData ignored.
  - +8 STATS: see Optional Feature.
  - +C: reserved; reads 0, writes ignored.
- ram_we = MemWrite && RAM region. Combinational, no latency.
- ReadData is combinational:
  - RAM region: ram_rd.
  - IO region: IO register value.
  - Unmapped: 0.
- STATUS word layout:
  - bit0 empty, bit1 full, bit2 overflow.
  - bits[15:8] count, zero-extended.
  - All other bits 0.
- Push condition: rising clk with MemWrite && DataAdr==IO_BASE+0.
  - Accepted when count<DEPTH, or count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the data is dropped and overflow is set (sticky).
- Pop condition: periph_valid && periph_ready at a rising clk.
- periph_valid = !empty; periph_data = mem[rd_ptr].
  - No fall-through: after a push into an empty FIFO, periph_valid rises the following cycle.
  - periph_data is stable while periph_valid && !periph_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Push only: count+1. Pop only: count-1. Both: unchanged.
- Overflow handling:
  - A write to STATUS clears overflow.
  - If a rejected push and a STATUS clear happen in the same cycle, the set wins.
- Reset (asynchronous, asserted low), applied immediately, mid-transfer included:
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0, all FIFO entries=0.
  - Therefore periph_valid=0 and periph_data=0.
  - Any in-flight handshake is abandoned; no partial state survives.
  - ReadData and ram_we remain combinational functions of their inputs during reset.

Optional Feature:
- Macro: MMIO_STATS_EN.
- Defined:
  - A 32-bit drained-word counter increments on every pop and wraps at 2^32.
  - Readable at IO_BASE+8; a write to +8 clears it.
  - If a clear and a pop occur in the same cycle, the result is 1.
  - Reset value is 0.
- Not defined: no counter exists; +8 reads 0 and writes are ignored.

Decomposition:
- Package mmio_pkg:
  - Offset constants OFF_DATA=4'h0, OFF_STATUS=4'h4, OFF_STATS=4'h8.
  - Status bit positions.
  - typedef region_t enum {REG_RAM, REG_IO, REG_UNMAPPED}.
- One natural sub-module: sync_fifo.
  - Parameterised by DEPTH and width.
  - Has push/pop/full/empty/count plus head data.
- mmio_store_buffer owns the decode, read mux, overflow flag and optional counter.

Test Plan:
- Store 32'hDEAD_BEEF to address 0x0000_0010, then load it back: ram_we=1 in that cycle; FIFO untouched; ReadData=ram_rd.
- periph_ready=0; store 0x11, 0x22, 0x33 to IO_BASE: STATUS reads 32'h0000_0300; periph_valid=1 with periph_data=0x11. Raise periph_ready: 0x11, 0x22, 0x33 drain on consecutive cycles, then empty, STATUS=32'h0000_0001.
- periph_ready=0; push 9 words with DEPTH=8: the 9th is dropped; STATUS=32'h0000_0806 (full, overflow). A write to IO_BASE+4 clears it to 32'h0000_0802.
- FIFO full with periph_ready=1 and a simultaneous push: push accepted, count stays 8, overflow stays 0.
- Reset pulled low mid-drain with 4 entries and ready=1: periph_valid=0 and periph_data=0 immediately; after release STATUS=32'h0000_0001.
- With MMIO_STATS_EN: drain 5 words, read IO_BASE+8 = 5. Write +8 in the same cycle as a pop, then read = 1. Without the macro, the read returns 0.
